// File: rtl/indicator_pkg.sv
// -----------------------------------------------------------------------------
// indicator_pkg
// Shared types and constants for the indicator bitmap epoch controller.
//   state_t        : sequencer states
//   SHIFT_DEFAULT  : default counter shift used to derive an indicator bit
//   WORD_W         : width of the packed dump word
//   calc_entries() : number of bitmap entries (counters x slices)
// -----------------------------------------------------------------------------
package indicator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCEPT,
        ST_FULL,
        ST_DUMP
    } state_t;

    localparam int SHIFT_DEFAULT = 3;
    localparam int WORD_W        = 32;

    function automatic int calc_entries(input int num_counter, input int num_slice);
        return num_counter * num_slice;
    endfunction

endpackage

// File: rtl/indicator_bitmap_ram.sv
// -----------------------------------------------------------------------------
// indicator_bitmap_ram
// 1-bit x DEPTH single-port RAM, synchronous read (1-cycle latency), no reset.
// The read register holds its value on write cycles.
//   Clk   : clock
//   addr  : read/write address
//   we    : write enable
//   wdata : write data bit
//   rdata : registered read data
// -----------------------------------------------------------------------------
module indicator_bitmap_ram #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic              wdata,
    output logic              rdata
);

    logic mem [DEPTH];

    always_ff @(posedge Clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/indicator_sched.sv
// -----------------------------------------------------------------------------
// indicator_sched
// Epoch controller for the per-slice indicator bitmap. Sequences the bitmap RAM
// through clear, accept and dump phases, forwards the counter stream and serves
// single-bit queries while the sequencer is not using the RAM.
//
// Optional feature: INDICATOR_POPCOUNT_EN builds the Set_Count counter;
// without it Set_Count is tied to 0.
//
// Ports:
//   Clk, Reset_n                   clock, async active-low reset
//   Start                          begin a new epoch (IDLE/FULL only)
//   Cnt_Valid/Cnt_Ready/Cnt_Data   counter stream in, entry order 0..N-1
//   Fwd_Valid/Fwd_Data             registered copy of accepted counters
//   Dump_Req                       read out bitmap (FULL only)
//   Rd_Valid/Rd_Data/Rd_Last       packed dump words, LSB-first, no backpressure
//   Qry_Valid/Qry_Ready/Qry_Addr   single-bit query request
//   Qry_Resp_Valid/Qry_Bit         query response, 1 cycle after handshake
//   Busy                           CLEAR, ACCEPT or DUMP
//   Done                           pulse on first FULL cycle
//   Set_Count                      number of indicators set this epoch
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | no epoch active, queries allowed
// ST_CLEAR  | zeroing entries 0..N-1, one per cycle
// ST_ACCEPT | taking counters, writing one indicator bit per handshake
// ST_FULL   | epoch complete, queries allowed, waiting for Start/Dump_Req
// ST_DUMP   | reading entries 0..N-1 and packing them into words
// -----------------------------------------------------------------------------
module indicator_sched
    import indicator_pkg::*;
#(
    parameter int NUM_COUNTER = 10,
    parameter int NUM_SLICE   = 3,
    parameter int SHIFT       = SHIFT_DEFAULT,
    parameter int ADDR_W      = 10,
    parameter int DEPTH       = 1024
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Cnt_Valid,
    output logic              Cnt_Ready,
    input  logic [31:0]       Cnt_Data,
    output logic              Fwd_Valid,
    output logic [31:0]       Fwd_Data,
    input  logic              Dump_Req,
    output logic              Rd_Valid,
    output logic [31:0]       Rd_Data,
    output logic              Rd_Last,
    input  logic              Qry_Valid,
    output logic              Qry_Ready,
    input  logic [ADDR_W-1:0] Qry_Addr,
    output logic              Qry_Resp_Valid,
    output logic              Qry_Bit,
    output logic              Busy,
    output logic              Done,
    output logic [15:0]       Set_Count
);

    localparam int                N        = calc_entries(NUM_COUNTER, NUM_SLICE);
    localparam logic [31:0]       N_U      = 32'(N);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
    localparam int                POS_W    = $clog2(WORD_W);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   idx;
    logic                idx_last;
    logic                cnt_hs, qry_hs, cnt_bit;
    logic                issue_rd;
    logic                rd_pend, rd_last;
    logic [POS_W-1:0]    rd_pos;
    logic [WORD_W-1:0]   word_acc, word_nxt;
    logic                qry_pend, qry_in_range;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we, ram_wdata, ram_q;

    assign idx_last  = (idx == LAST_IDX);
    assign Cnt_Ready = (state == ST_ACCEPT);
    assign Qry_Ready = (state == ST_IDLE) || (state == ST_FULL);
    assign Busy      = (state == ST_CLEAR) || (state == ST_ACCEPT) || (state == ST_DUMP);
    assign cnt_hs    = Cnt_Valid && Cnt_Ready;
    assign qry_hs    = Qry_Valid && Qry_Ready;
    assign cnt_bit   = |(Cnt_Data >> SHIFT);

    // Stop issuing reads once the final entry is in the read pipeline.
    assign issue_rd  = (state == ST_DUMP) && !(rd_pend && rd_last);
    assign word_nxt  = word_acc | (WORD_W'(ram_q) << rd_pos);

    // Response is gated so out-of-range (never cleared) entries read as 0.
    assign Qry_Resp_Valid = qry_pend;
    assign Qry_Bit        = qry_pend && qry_in_range && ram_q;

    always_comb begin
        state_nxt = state;
        ram_addr  = Qry_Addr;
        ram_we    = 1'b0;
        ram_wdata = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (Start) state_nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                ram_addr = idx;
                ram_we   = 1'b1;
                if (idx_last) state_nxt = ST_ACCEPT;
            end
            ST_ACCEPT: begin
                ram_addr  = idx;
                ram_we    = cnt_hs;
                ram_wdata = cnt_bit;
                if (cnt_hs && idx_last) state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (Start)         state_nxt = ST_CLEAR;
                else if (Dump_Req) state_nxt = ST_DUMP;
            end
            ST_DUMP: begin
                ram_addr = idx;
                if (rd_pend && rd_last) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            Done         <= 1'b0;
            Fwd_Valid    <= 1'b0;
            Fwd_Data     <= '0;
            qry_pend     <= 1'b0;
            qry_in_range <= 1'b0;
            rd_pend      <= 1'b0;
            rd_last      <= 1'b0;
            rd_pos       <= '0;
            word_acc     <= '0;
            Rd_Valid     <= 1'b0;
            Rd_Data      <= '0;
            Rd_Last      <= 1'b0;
        end else begin
            state <= state_nxt;

            // Every phase starts at entry 0.
            if (state_nxt != state) begin
                idx <= '0;
            end else if ((state == ST_CLEAR) || cnt_hs || issue_rd) begin
                idx <= idx + 1'b1;
            end

            Done      <= cnt_hs && idx_last;
            Fwd_Valid <= cnt_hs;
            if (cnt_hs) Fwd_Data <= Cnt_Data;

            qry_pend <= qry_hs;
            if (qry_hs) qry_in_range <= (32'(Qry_Addr) < N_U);

            rd_pend <= issue_rd;
            if (issue_rd) begin
                rd_last <= idx_last;
                rd_pos  <= idx[POS_W-1:0];
            end

            Rd_Valid <= 1'b0;
            Rd_Last  <= 1'b0;
            if (rd_pend) begin
                if ((rd_pos == POS_W'(WORD_W - 1)) || rd_last) begin
                    Rd_Valid <= 1'b1;
                    Rd_Data  <= word_nxt;
                    Rd_Last  <= rd_last;
                    word_acc <= '0;
                end else begin
                    word_acc <= word_nxt;
                end
            end
        end
    end

`ifdef INDICATOR_POPCOUNT_EN
    logic [15:0] set_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            set_cnt <= '0;
        end else if ((state_nxt == ST_CLEAR) && (state != ST_CLEAR)) begin
            set_cnt <= '0;
        end else if (cnt_hs && cnt_bit) begin
            set_cnt <= set_cnt + 16'd1;
        end
    end

    assign Set_Count = set_cnt;
`else
    assign Set_Count = '0;
`endif

    indicator_bitmap_ram #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .Clk   (Clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_indicator_sched.sv
// -----------------------------------------------------------------------------
// tb_indicator_sched
// Directed bench for indicator_sched. Instance 0 uses N=30, instance 1 N=40.
// Inputs are driven 1 time unit after the rising edge and outputs are sampled
// at the same point, so each sample shows the result of the preceding edge.
// -----------------------------------------------------------------------------
module tb_indicator_sched;

`ifdef INDICATOR_POPCOUNT_EN
    localparam bit POP_EN = 1'b1;
`else
    localparam bit POP_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n          [2];
    logic        start          [2];
    logic        cnt_valid      [2];
    logic        cnt_ready      [2];
    logic [31:0] cnt_data       [2];
    logic        fwd_valid      [2];
    logic [31:0] fwd_data       [2];
    logic        dump_req       [2];
    logic        rd_valid       [2];
    logic [31:0] rd_data        [2];
    logic        rd_last        [2];
    logic        qry_valid      [2];
    logic        qry_ready      [2];
    logic [9:0]  qry_addr       [2];
    logic        qry_resp_valid [2];
    logic        qry_bit        [2];
    logic        busy           [2];
    logic        done           [2];
    logic [15:0] set_count      [2];

    int checks   = 0;
    int failures = 0;

    indicator_sched #(.NUM_COUNTER(10), .NUM_SLICE(3)) u_dut0 (
        .Clk(clk), .Reset_n(rst_n[0]), .Start(start[0]),
        .Cnt_Valid(cnt_valid[0]), .Cnt_Ready(cnt_ready[0]), .Cnt_Data(cnt_data[0]),
        .Fwd_Valid(fwd_valid[0]), .Fwd_Data(fwd_data[0]), .Dump_Req(dump_req[0]),
        .Rd_Valid(rd_valid[0]), .Rd_Data(rd_data[0]), .Rd_Last(rd_last[0]),
        .Qry_Valid(qry_valid[0]), .Qry_Ready(qry_ready[0]), .Qry_Addr(qry_addr[0]),
        .Qry_Resp_Valid(qry_resp_valid[0]), .Qry_Bit(qry_bit[0]),
        .Busy(busy[0]), .Done(done[0]), .Set_Count(set_count[0])
    );

    indicator_sched #(.NUM_COUNTER(10), .NUM_SLICE(4)) u_dut1 (
        .Clk(clk), .Reset_n(rst_n[1]), .Start(start[1]),
        .Cnt_Valid(cnt_valid[1]), .Cnt_Ready(cnt_ready[1]), .Cnt_Data(cnt_data[1]),
        .Fwd_Valid(fwd_valid[1]), .Fwd_Data(fwd_data[1]), .Dump_Req(dump_req[1]),
        .Rd_Valid(rd_valid[1]), .Rd_Data(rd_data[1]), .Rd_Last(rd_last[1]),
        .Qry_Valid(qry_valid[1]), .Qry_Ready(qry_ready[1]), .Qry_Addr(qry_addr[1]),
        .Qry_Resp_Valid(qry_resp_valid[1]), .Qry_Bit(qry_bit[1]),
        .Busy(busy[1]), .Done(done[1]), .Set_Count(set_count[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] value_for(input int mode, input int k);
        case (mode)
            0:       return 32'(k);
            1:       return 32'd8;
            2:       return (k % 3 == 0) ? 32'd8 : 32'd1;
            3:       return 32'd100;
            default: return (k % 2 == 1) ? 32'(16 + k) : 32'(k % 8);
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int i, input int exp_cyc);
        int cyc = 0;
        start[i] = 1'b1;
        while (cyc < 2000) begin
            step();
            start[i] = 1'b0;
            cyc++;
            if (cnt_ready[i]) break;
        end
        check_eq("clear_len", cyc, exp_cyc);
    endtask

    task automatic feed(input int i, input int n, input int mode, input bit rnd,
                        input int start_at, input int stop_after);
        int          hs = 0;
        int          budget = 0;
        bit          hs_prev;
        logic [31:0] d_prev;
        bit          start_done = 1'b0;
        while (hs < stop_after && budget < 1000) begin
            cnt_valid[i] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cnt_data[i]  = value_for(mode, hs);
            if (start_at >= 0 && hs == start_at && !start_done) begin
                start[i]   = 1'b1;
                start_done = 1'b1;
            end
            hs_prev = cnt_valid[i] && cnt_ready[i];
            d_prev  = cnt_data[i];
            step();
            start[i] = 1'b0;
            budget++;
            check_eq("fwd_valid", fwd_valid[i], hs_prev);
            if (hs_prev) begin
                check_eq("fwd_data", fwd_data[i], d_prev);
                hs++;
            end
            check_eq("done", done[i], hs == n);
            check_eq("cnt_ready", cnt_ready[i], hs < n);
        end
        cnt_valid[i] = 1'b0;
        check_eq("feed_count", hs, stop_after);
    endtask

    task automatic query(input int i, input int addr, input bit exp_bit);
        qry_valid[i] = 1'b1;
        qry_addr[i]  = 10'(addr);
        check_eq("qry_ready", qry_ready[i], 1);
        step();
        qry_valid[i] = 1'b0;
        check_eq("qry_resp_valid", qry_resp_valid[i], 1);
        check_eq("qry_bit", qry_bit[i], exp_bit);
    endtask

    task automatic do_dump(input int i, input int nwords, input logic [31:0] e0,
                           input logic [31:0] e1, input int lat0);
        int cyc = 0;
        int w = 0;
        int qbad = 0;
        dump_req[i] = 1'b1;
        while (w < nwords && cyc < 300) begin
            step();
            dump_req[i] = 1'b0;
            cyc++;
            if (rd_valid[i]) begin
                if (w == 0) begin
                    check_eq("dump_lat", cyc, lat0);
                    check_eq("word0", rd_data[i], e0);
                end else begin
                    check_eq("word1", rd_data[i], e1);
                end
                check_eq("rd_last", rd_last[i], w == nwords - 1);
                w++;
            end else if (qry_ready[i]) begin
                qbad++;
            end
        end
        check_eq("dump_words", w, nwords);
        check_eq("qry_ready_in_dump", qbad, 0);
        check_eq("busy_after_dump", busy[i], 0);
    endtask

    task automatic check_reset_vals(input int i, input string tag);
        check_eq({tag, "_busy"},      busy[i], 0);
        check_eq({tag, "_cnt_ready"}, cnt_ready[i], 0);
        check_eq({tag, "_qry_ready"}, qry_ready[i], 1);
        check_eq({tag, "_done"},      done[i], 0);
        check_eq({tag, "_fwd_valid"}, fwd_valid[i], 0);
        check_eq({tag, "_fwd_data"},  fwd_data[i], 0);
        check_eq({tag, "_rd_valid"},  rd_valid[i], 0);
        check_eq({tag, "_rd_data"},   rd_data[i], 0);
        check_eq({tag, "_rd_last"},   rd_last[i], 0);
        check_eq({tag, "_qry_resp"},  qry_resp_valid[i], 0);
        check_eq({tag, "_qry_bit"},   qry_bit[i], 0);
        check_eq({tag, "_set_count"}, set_count[i], 0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst_n[i]     = 1'b0;
            start[i]     = 1'b0;
            cnt_valid[i] = 1'b0;
            cnt_data[i]  = '0;
            dump_req[i]  = 1'b0;
            qry_valid[i] = 1'b0;
            qry_addr[i]  = '0;
        end
        repeat (3) step();
        check_reset_vals(0, "por");
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        step();

        // Epoch 1 on N=30: values 0..29, indicators set for 8..29.
        do_start(0, 31);
        feed(0, 30, 0, 1'b0, -1, 30);
        check_eq("set_count_e1", set_count[0], POP_EN ? 22 : 0);
        query(0, 7, 1'b0);
        query(0, 8, 1'b1);
        query(0, 35, 1'b0);
        step();
        check_eq("qry_resp_idle", qry_resp_valid[0], 0);
        do_dump(0, 1, 32'h3FFF_FF00, 32'h0, 32);

        // N=40, all counters = 8: every indicator set.
        do_start(1, 41);
        feed(1, 40, 1, 1'b0, -1, 40);
        check_eq("set_count_n40", set_count[1], POP_EN ? 40 : 0);
        do_dump(1, 2, 32'hFFFF_FFFF, 32'h0000_00FF, 34);

        // Reset after the 12th handshake of an all-ones epoch.
        do_start(0, 31);
        feed(0, 30, 3, 1'b0, -1, 12);
        rst_n[0] = 1'b0;
        #1;
        check_reset_vals(0, "mid_rst");
        step();
        rst_n[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq("post_rst_done", done[0], 0);
            check_eq("post_rst_fwd", fwd_valid[0], 0);
            check_eq("post_rst_busy", busy[0], 0);
        end
        do_start(0, 31);
        feed(0, 30, 2, 1'b0, -1, 30);
        check_eq("set_count_e3", set_count[0], POP_EN ? 10 : 0);
        do_dump(0, 1, 32'h0924_9249, 32'h0, 32);

        // Random valid gaps with a Start pulse mid-ACCEPT on N=40.
        do_start(1, 41);
        feed(1, 40, 4, 1'b1, 15, 40);
        check_eq("set_count_rand", set_count[1], POP_EN ? 20 : 0);
        do_dump(1, 2, 32'hAAAA_AAAA, 32'h0000_00AA, 34);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/indicator_sched.md
# indicator_sched

Epoch controller for the per-slice indicator bitmap, which holds one bit per (counter, slice) entry and records whether that counter has exceeded the low-order range.
- Sequences the shared bitmap RAM through clear, accept and dump phases.
- Forwards the counter stream downstream.
- Arbitrates a single-bit query port against the sequencer's own RAM accesses.
- Sits between the slice counter array and the layer-2 tree builder / host readout.

## Interface
- NUM_COUNTER, 10, counters per slice
- NUM_SLICE, 3, slices; N = NUM_COUNTER*NUM_SLICE entries, N ≤ DEPTH
- SHIFT, 3, indicator set when (counter >> SHIFT) != 0
- ADDR_W, 10, bitmap address width
- DEPTH, 1024, bitmap depth = 2^ADDR_W
- Clk  in  1  clock
- Reset_n  in  1  reset, asynchronous, active-low
- Start  in  1  pulse: begin a new epoch
- Cnt_Valid / Cnt_Ready  in / out  1 / 1  counter stream handshake
- Cnt_Data  in  32  counter value, entry order 0..N-1
- Fwd_Valid  out  1  forwarded counter valid
- Fwd_Data  out  32  forwarded counter
- Dump_Req  in  1  pulse: read out bitmap
- Rd_Valid  out  1  packed word valid; no backpressure
- Rd_Data  out  32  packed word
- Rd_Last  out  1  final packed word
- Qry_Valid / Qry_Ready  in / out  1 / 1  query handshake
- Qry_Addr  in  ADDR_W  entry to query
- Qry_Resp_Valid  out  1  query response valid
- Qry_Bit  out  1  queried bit
- Busy  out  1  state is CLEAR, ACCEPT or DUMP
- Done  out  1  one-cycle pulse when accept phase completes
- Set_Count  out  16  number of set indicators (see Configuration)

## Operation
- States: IDLE, CLEAR, ACCEPT, FULL, DUMP. Reset enters IDLE.
- IDLE or FULL, Start=1 → CLEAR. Start is ignored in all other states.
- CLEAR: writes 0 to addresses 0..N-1, one per cycle, in exactly N cycles, then → ACCEPT.
- ACCEPT:
  - Cnt_Ready=1.
  - Each handshake k (0..N-1) writes bit[k] = |(Cnt_Data >> SHIFT), as a 0 or 1 write.
  - After the N-th handshake: → FULL with a Done pulse.
- FULL, Dump_Req=1 → DUMP. Dump_Req is ignored elsewhere. If Start and Dump_Req arrive in the same cycle in FULL, Start wins.
- DUMP:
  - Reads addresses 0..N-1 one per cycle.
  - Packs bits LSB-first: entry 32w+i goes to bit i of word w.
  - The final word is zero-padded, with Rd_Last=1.
  - → IDLE after the final word is emitted.
- Query:
  - Qry_Ready=1 only in IDLE and FULL, when the sequencer does not own the RAM.
  - A handshake reads Qry_Addr.
  - Qry_Addr ≥ N returns Qry_Bit=0.
- Cnt_Valid outside ACCEPT is ignored; Cnt_Ready=0.
- Bitmap RAM is not reset. Its contents are undefined after Reset_n until the next CLEAR completes.

## Timing
- Reset values: all outputs 0, except Qry_Ready=1 (IDLE). Internal index and word registers are 0.
- Bitmap RAM: synchronous read with 1-cycle latency, write on the edge.
- Fwd_Valid/Fwd_Data: registered copy of the handshake, 1 cycle after each Cnt handshake.
- Qry_Resp_Valid/Qry_Bit: 1 cycle after the query handshake.
  - A query accepted in the same cycle Start or Dump_Req is taken still completes.
  - The state leaves IDLE/FULL one cycle later.
- Rd_Valid: word w is asserted 1 cycle after the read of its last address. The first word appears 33 cycles after DUMP entry when N ≥ 32.
- Done: asserted in the cycle after the N-th handshake edge, coincident with the first FULL cycle.
- Reset mid-epoch: immediate return to IDLE; no Done, Rd_Last or Fwd_Valid is emitted afterwards.

## Configuration
- INDICATOR_POPCOUNT_EN defined:
  - Set_Count is cleared on CLEAR entry.
  - It increments by 1 on each ACCEPT write of 1, registered alongside the write.
  - It holds through FULL and DUMP.
- Undefined: Set_Count is tied to 0 and no counter logic is built.

## Structure
- Package indicator_pkg:
  - state enum
  - localparam function for N
  - SHIFT default
  - packed-word width constant (32)
- Sub-module indicator_bitmap_ram: 1-bit × DEPTH, single port, sync read, no reset. The controller muxes its address, write-enable and data between the sequencer and the query port.

## Test plan
- Reset, then Start with N=30, SHIFT=3 → 30 CLEAR cycles, then Cnt_Ready=1. Feed values 0..29 → Done in the cycle after the 30th handshake; Set_Count=22 (values 8..29) when the macro is defined, 0 when it is undefined.
- Dump after that epoch → one word, Rd_Data=0x3FFFFF00, Rd_Last=1.
- With N=40: feed all counters=8, then Dump → word0=0xFFFFFFFF, then word1=0x000000FF with Rd_Last=1.
- In FULL, query addresses 7 and 8, then 35 → Qry_Bit=0, 1, then 0, each 1 cycle after its handshake; Qry_Ready=0 throughout DUMP.
- Assert Reset_n low after the 12th ACCEPT handshake → all outputs return to reset values. A following Start re-clears, and a fresh dump shows only the new epoch's bits.
- Toggle Cnt_Valid randomly during ACCEPT and pulse Start mid-ACCEPT → Start is ignored, every write address is sequential, and Fwd_Data matches the inputs 1 cycle later.
